edge_detection_stream: RTL

EDGE_DETECTION_STREAM -- requirements
Module: edge_detection_stream

---
 rtl/edge_pkg.sv | 18 +
 rtl/line_buffer.sv | 24 ++
 rtl/edge_detection_stream.sv | 138 +++++++++++++
 3 files changed

// File: rtl/edge_pkg.sv
// Shared types and constants for the streaming 3x3 edge detector.
package edge_pkg;

  typedef enum logic [1:0] {
    MODE_LAP4   = 2'd0,
    MODE_LAP8   = 2'd1,
    MODE_BYPASS = 2'd2
  } mode_e;

  localparam int SHIFT_LAP4 = 2;
  localparam int SHIFT_LAP8 = 3;

  // The reserved encoding 3 behaves like the 4-neighbour Laplacian.
  function automatic mode_e decode_mode(input logic [1:0] m);
    return (m == 2'd3) ? MODE_LAP4 : mode_e'(m);
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One-line delay: reads the entry at addr (previous line) and overwrites it in the same cycle.
module line_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 640,
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign dout = mem[addr];

  // NOTE: storage arrays carry no reset; every entry is rewritten before a valid output reads it,
  // and leaving reset off lets the array map onto RAM.
  always_ff @(posedge clk) begin
    if (en) mem[addr] <= din;
  end

endmodule

// File: rtl/edge_detection_stream.sv
// Raster-stream 3x3 Laplacian edge detector with optional binarisation, fixed 2-cycle latency.
module edge_detection_stream
  import edge_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] threshold,
  input  logic                  s_valid,
  input  logic                  s_sof,
  input  logic [DATA_WIDTH-1:0] s_pixel,
  output logic                  m_valid,
  output logic                  m_sof,
  output logic [DATA_WIDTH-1:0] m_pixel
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int W4 = DATA_WIDTH + 3;
  localparam int W8 = DATA_WIDTH + 5;
  localparam logic [CW-1:0]         COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0]         ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [DATA_WIDTH-1:0] PIX_MAX  = '1;

  logic [CW-1:0]         col_q, pos_col;
  logic [RW-1:0]         row_q, pos_row;
  logic                  active_q, accept;
  mode_e                 mode_q;
  logic [DATA_WIDTH-1:0] thr_q;
  logic                  v1_q, sof1_q;
  logic [DATA_WIDTH-1:0] lb0_out, lb1_out;
  logic [DATA_WIDTH-1:0] win [3][3];

  assign accept  = s_valid && (s_sof || active_q);
  assign pos_col = s_sof ? '0 : col_q;
  assign pos_row = s_sof ? '0 : row_q;

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q    <= '0;
      row_q    <= '0;
      active_q <= 1'b0;
      mode_q   <= MODE_LAP4;
      thr_q    <= '0;
      v1_q     <= 1'b0;
      sof1_q   <= 1'b0;
    end else begin
      v1_q   <= 1'b0;
      sof1_q <= 1'b0;
      if (accept) begin
        v1_q   <= (pos_row >= RW'(2)) && (pos_col >= CW'(2));
        sof1_q <= (pos_row == RW'(2)) && (pos_col == CW'(2));
        if (s_sof) begin
          active_q <= 1'b1;
          mode_q   <= decode_mode(mode);
          thr_q    <= threshold;
        end
        if (pos_col == COL_LAST) begin
          col_q <= '0;
          if (pos_row == ROW_LAST) begin
            row_q    <= '0;
            active_q <= 1'b0;
          end else begin
            row_q <= pos_row + 1'b1;
          end
        end else begin
          col_q <= pos_col + 1'b1;
          row_q <= pos_row;
        end
      end
    end
  end

  // lb0 yields row r-1 and lb1 row r-2 for the column being written.
  line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_lb0 (
    .clk(clk), .en(accept), .addr(pos_col), .din(s_pixel), .dout(lb0_out)
  );
  line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_lb1 (
    .clk(clk), .en(accept), .addr(pos_col), .din(lb0_out), .dout(lb1_out)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lb1_out;
      win[1][2] <= lb0_out;
      win[2][2] <= s_pixel;
    end
  end

  logic signed [W4-1:0]  lap4;
  logic signed [W8-1:0]  lap8;
  logic [W4-1:0]         abs4;
  logic [W8-1:0]         abs8, mag;
  logic [DATA_WIDTH-1:0] res_sat, res_out;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    lap4 = (W4'(win[1][1]) << 2) - W4'(win[0][1]) - W4'(win[2][1])
         - W4'(win[1][0]) - W4'(win[1][2]);
    lap8 = (W8'(win[1][1]) << 3)
         - W8'(win[0][0]) - W8'(win[0][1]) - W8'(win[0][2])
         - W8'(win[1][0]) - W8'(win[1][2])
         - W8'(win[2][0]) - W8'(win[2][1]) - W8'(win[2][2]);
    abs4 = lap4[W4-1] ? W4'(-lap4) : W4'(lap4);
    abs8 = lap8[W8-1] ? W8'(-lap8) : W8'(lap8);
    mag  = '0;
    case (mode_q)
      MODE_LAP8:   mag = abs8 >> SHIFT_LAP8;
      MODE_BYPASS: mag = W8'(win[1][1]);
      default:     mag = W8'(abs4 >> SHIFT_LAP4);
    endcase
    res_sat = (mag > W8'(PIX_MAX)) ? PIX_MAX : mag[DATA_WIDTH-1:0];
    res_out = res_sat;
    if (thr_q != '0) res_out = (res_sat >= thr_q) ? PIX_MAX : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_sof   <= 1'b0;
      m_pixel <= '0;
    end else begin
      m_valid <= v1_q;
      m_sof   <= sof1_q;
      if (v1_q) m_pixel <= res_out;
    end
  end

endmodule
